// File: rtl/i2c_temp_poll_ctrl_pkg.sv
// i2c_temp_poll_ctrl_pkg: controller state encoding and default sensor constants
package i2c_temp_poll_ctrl_pkg;
    typedef enum logic [2:0] {
        CFG_GO,
        CFG_WAIT,
        POLL_WAIT,
        RD_GO,
        RD_WAIT,
        PUBLISH
    } state_t;
    localparam logic [6:0] DEF_DEV_ADDR = 7'h48;
    localparam logic [7:0] DEF_CFG_PTR  = 8'h01;
    localparam logic [7:0] DEF_CFG_VAL  = 8'h60;
    localparam logic [7:0] DEF_TEMP_PTR = 8'h00;
endpackage

// File: rtl/i2c_poll_timer.sv
// i2c_poll_timer: clearable counter giving a one-cycle tc pulse at count limit-1
module i2c_poll_timer
    import i2c_temp_poll_ctrl_pkg::*;
#(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt;
    assign tc = en && !clr && (cnt == limit - 1'b1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr || tc) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/i2c_temp_poll_ctrl.sv
// i2c_temp_poll_ctrl: configures the temperature sensor once, then polls it through the I2C master
module i2c_temp_poll_ctrl
    import i2c_temp_poll_ctrl_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = DEF_DEV_ADDR,
    parameter logic [7:0]  CFG_PTR        = DEF_CFG_PTR,
    parameter logic [7:0]  CFG_VAL        = DEF_CFG_VAL,
    parameter logic [7:0]  TEMP_PTR       = DEF_TEMP_PTR,
    parameter logic [25:0] POLL_CYCLES    = 26'd50_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        m_go,
    input  logic        m_done,
    input  logic        m_ready,
    output logic        m_rw,
    output logic [5:0]  m_nbyte,
    output logic [6:0]  m_dev_add,
    output logic [7:0]  m_dwr,
    output logic [7:0]  m_rptr,
    input  logic [7:0]  m_drd,
    input  logic        m_ack_e,
    output logic        m_stop,
    output logic [11:0] temp_raw,
    output logic [7:0]  temp_int,
    output logic        temp_valid,
    output logic        nack_err,
    output logic        timeout_err,
    output logic        busy
);
    state_t state, nxt;
    logic rdy_q, done_q, ack_evt, poll_tc, to_tc;
    logic [1:0] byte_cnt;
    logic [7:0] msb_r, lsb_r;
    logic rdy_rise, done_rise, in_wait, go_next, unused_ok;

    assign rdy_rise  = m_ready & ~rdy_q;
    assign done_rise = m_done & ~done_q;
    assign in_wait   = (state == CFG_WAIT) || (state == RD_WAIT);
    assign go_next   = (nxt == CFG_GO) || (nxt == RD_GO);
    assign m_dev_add = DEV_ADDR;
    assign m_stop    = 1'b0;
    assign busy      = state != POLL_WAIT;
    assign unused_ok = ^lsb_r[3:0];

    i2c_poll_timer #(.W(26)) u_poll (
        .clk(clk), .reset(reset), .en(state == POLL_WAIT), .clr(state != POLL_WAIT),
        .limit(POLL_CYCLES), .tc(poll_tc)
    );

    i2c_poll_timer #(.W(24)) u_timeout (
        .clk(clk), .reset(reset), .en(in_wait), .clr(!in_wait),
        .limit(TIMEOUT_CYCLES), .tc(to_tc)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= CFG_GO;
        else state <= nxt;

    // acceptance requires our own go to be up, so a still-busy master is never mistaken for one
    always_comb begin
        nxt = state;
        case (state)
            CFG_GO:    nxt = (m_go && !m_done) ? CFG_WAIT : CFG_GO;
            CFG_WAIT:  nxt = done_rise ? POLL_WAIT : (to_tc ? CFG_GO : CFG_WAIT);
            POLL_WAIT: nxt = poll_tc ? RD_GO : POLL_WAIT;
            RD_GO:     nxt = (m_go && !m_done) ? RD_WAIT : RD_GO;
            RD_WAIT:   nxt = done_rise ? PUBLISH : (to_tc ? POLL_WAIT : RD_WAIT);
            PUBLISH:   nxt = POLL_WAIT;
            default:   nxt = CFG_GO;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rdy_q       <= 1'b0;
            done_q      <= 1'b0;
            ack_evt     <= 1'b0;
            m_go        <= 1'b0;
            m_rw        <= 1'b0;
            m_nbyte     <= '0;
            m_dwr       <= '0;
            m_rptr      <= '0;
            byte_cnt    <= '0;
            msb_r       <= '0;
            lsb_r       <= '0;
            temp_raw    <= '0;
            temp_int    <= '0;
            temp_valid  <= 1'b0;
            nack_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rdy_q      <= m_ready;
            done_q     <= m_done;
            ack_evt    <= done_rise & m_ack_e;
            m_go       <= go_next && m_done;
            temp_valid <= 1'b0;
            if (nxt == CFG_GO) begin
                m_rw    <= 1'b0;
                m_nbyte <= 6'd1;
                m_rptr  <= CFG_PTR;
                m_dwr   <= CFG_VAL;
            end
            if (nxt == RD_GO) begin
                m_rw    <= 1'b1;
                m_nbyte <= 6'd2;
                m_rptr  <= TEMP_PTR;
            end
            if (state == RD_GO && nxt == RD_WAIT) byte_cnt <= '0;
            if (state == RD_WAIT && rdy_rise) begin
                if (byte_cnt == 2'd0) msb_r <= m_drd;
                if (byte_cnt == 2'd1) lsb_r <= m_drd;
                byte_cnt <= (byte_cnt == 2'd2) ? 2'd2 : byte_cnt + 2'd1;
            end
            if (state == CFG_WAIT && done_rise && m_ack_e) nack_err <= 1'b1;
            if (in_wait && to_tc && !done_rise) timeout_err <= 1'b1;
            if (state == PUBLISH) begin
                if (!ack_evt && byte_cnt == 2'd2) begin
                    temp_raw    <= {msb_r, lsb_r[7:4]};
                    temp_int    <= msb_r;
                    temp_valid  <= 1'b1;
                    nack_err    <= 1'b0;
                    timeout_err <= 1'b0;
                end else begin
                    nack_err <= 1'b1;
                end
            end
        end
endmodule

// File: doc/i2c_temp_poll_ctrl.md
Name: i2c_temp_poll_ctrl

Overview:
Command sequencer that sits directly upstream of the I2C master and drives its go/rw/N_Byte/dev_add/R_Pointer/dwr_DataWriteReg inputs. After reset it writes one configuration byte to the temperature sensor, then polls the 2-byte temperature register at a fixed interval. It assembles the two bytes returned on drd_lcdData into a temperature word for the LCD formatter, and flags NACKs and hung transactions.

Parameters:
DEV_ADDR, 7'h48, sensor 7-bit slave address
CFG_PTR, 8'h01, configuration register pointer
CFG_VAL, 8'h60, configuration byte written once after reset
TEMP_PTR, 8'h00, temperature register pointer
POLL_CYCLES, 26'd50_000_000, clk cycles from end of one read to the next go
TIMEOUT_CYCLES, 24'd4_000_000, max clk cycles from go accepted to done

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
m_go  out  1  to master go
m_done  in  1  from master done (1 = idle/finished)
m_ready  in  1  from master ready
m_rw  out  1  to master rw (0 = write, 1 = read)
m_nbyte  out  6  to master N_Byte
m_dev_add  out  7  to master dev_add, constant DEV_ADDR
m_dwr  out  8  to master dwr_DataWriteReg
m_rptr  out  8  to master R_Pointer
m_drd  in  8  from master drd_lcdData
m_ack_e  in  1  from master ack_e (1 = NACK seen)
m_stop  out  1  to master stop, tied 0
temp_raw  out  12  {MSB, LSB[7:4]}, two's complement, 1/16 degC LSB
temp_int  out  8  signed integer degC (the MSB)
temp_valid  out  1  one-cycle pulse when temp_raw/temp_int update
nack_err  out  1  sticky; set on NACK, cleared on next clean read
timeout_err  out  1  sticky; set on timeout, cleared on next clean read
busy  out  1  high in every state except POLL_WAIT

Behaviour:
- Reset (reset == 0, async): state = CFG_GO. m_go = 0, m_rw = 0, m_nbyte = 0, m_dwr = 0, m_rptr = 0. temp_raw = 0, temp_int = 0, temp_valid = 0, nack_err = 0, timeout_err = 0. Poll and timeout counters = 0. byte_cnt = 0.
- m_ready is level-high across several master states. Register it once and use the rising edge (rdy_rise) as the byte event.
- m_ack_e is sampled only in the cycle m_done rises. ack_evt is a one-cycle flag set on that sample.
- States:
  - CFG_GO: m_rw = 0, m_nbyte = 1, m_rptr = CFG_PTR, m_dwr = CFG_VAL, m_go = 1. When m_done == 0, the master has accepted: m_go <= 0, clear timeout counter, -> CFG_WAIT.
  - CFG_WAIT: hold m_dwr stable. On m_done rising -> POLL_WAIT; set nack_err if m_ack_e == 1.
  - POLL_WAIT: poll counter counts 0..POLL_CYCLES-1. At the terminal count, clear the counter -> RD_GO. First entry after config uses the full interval.
  - RD_GO: m_rw = 1, m_nbyte = 2, m_rptr = TEMP_PTR, m_go = 1. When m_done == 0: m_go <= 0, byte_cnt <= 0, -> RD_WAIT.
  - RD_WAIT: on rdy_rise, byte_cnt 0 latches m_drd into msb_r and byte_cnt 1 latches m_drd into lsb_r; byte_cnt saturates at 2. On m_done rising -> PUBLISH.
  - PUBLISH (1 cycle):
    - If m_ack_e == 0 and byte_cnt == 2: update temp_raw and temp_int, pulse temp_valid, clear nack_err and timeout_err.
    - Otherwise set nack_err and leave the outputs unchanged.
    - -> POLL_WAIT.
- Timeout: in CFG_WAIT or RD_WAIT the timeout counter increments every cycle. At TIMEOUT_CYCLES-1: set timeout_err, m_go = 0.
  - From CFG_WAIT -> CFG_GO (retry config).
  - From RD_WAIT -> POLL_WAIT.
- Go handshake: m_go stays high until m_done is observed 0; it is never asserted while m_done == 0 at state entry. In CFG_GO/RD_GO, m_go is driven only when m_done == 1.
- Simultaneous rdy_rise and m_done rising in RD_WAIT: capture the byte first, then PUBLISH sees the updated byte_cnt.
- Reset mid-transaction: controller returns to CFG_GO with m_go = 0. The master's reset is separate.
- temp_valid is never high for two consecutive cycles.

Decomposition:
- Shared package: state encoding constants (CFG_GO, CFG_WAIT, POLL_WAIT, RD_GO, RD_WAIT, PUBLISH) and default sensor constants (DEV_ADDR, CFG_PTR, CFG_VAL, TEMP_PTR).
- One sub-module: i2c_poll_timer, a loadable terminal-count counter instanced twice (poll interval and timeout). Each instance has a clear input and a one-cycle tc pulse output.

Test Plan:
- Config write: bench master model accepts go (done falls 2 cycles later), 1 ready pulse, done rises with ack_e = 0 → m_rw = 0, m_nbyte = 1, m_rptr = 8'h01, m_dwr = 8'h60 held through done; nack_err = 0.
- Read 25.5 degC (POLL_CYCLES = 100): model returns 8'h19 then 8'h80 → temp_int = 8'h19, temp_raw = 12'h198, one temp_valid pulse; next m_go exactly 100 cycles after PUBLISH.
- Negative temperature: bytes 8'hE7, 8'h00 → temp_raw = 12'hE70, temp_int = -25.
- NACK: done rises with ack_e = 1 and 0 ready pulses → nack_err = 1, temp_raw unchanged, no temp_valid. Next clean read clears nack_err.
- Timeout (TIMEOUT_CYCLES = 50): model accepts go but never raises done → timeout_err = 1 after 50 cycles, state POLL_WAIT, m_go = 0.
- Async reset asserted during RD_WAIT between the two ready pulses → all outputs zero immediately. After release, m_go reasserts with m_rw = 0 (config first).
